// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source: FSM states, header layout,
// payload LFSR polynomial and the illegal destination code.
package router_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StParity,
        StGap
    } tx_state_e;

    localparam int unsigned HDR_ADDR_LSB = 0;
    localparam int unsigned HDR_ADDR_W   = 2;
    localparam int unsigned HDR_LEN_LSB  = 2;
    localparam int unsigned HDR_LEN_W    = 6;

    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;
    localparam logic [1:0] ADDR_ILLEGAL  = 2'b11;

    function automatic logic [7:0] make_header(input logic [5:0] len, input logic [1:0] addr);
        logic [7:0] h;
        h = '0;
        h[HDR_LEN_LSB +: HDR_LEN_W]   = len;
        h[HDR_ADDR_LSB +: HDR_ADDR_W] = addr;
        return h;
    endfunction

    // Galois right-shift step; a non-zero state never reaches zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Galois LFSR holding the payload byte currently on the wire.
// A zero seed is replaced so the register can never lock up.
module router_lfsr8
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= LFSR_ZERO_SUB;
        end else if (load) begin
            q_q <= (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
        end else if (enable) begin
            q_q <= lfsr_step(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router input: header, LFSR payload, then XOR parity,
// with stall on busy and optional parity corruption. All outputs are registered.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned MAX_LEN    = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic [7:0] cmd_seed,
    input  logic       cmd_bad_parity,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       cmd_err
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);

    tx_state_e       state_q, state_d;
    logic [5:0]      len_q, len_d;
    logic            bad_q, bad_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [7:0]      parity_q, parity_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;

    logic            lfsr_load;
    logic            lfsr_en;
    logic [7:0]      lfsr_q;
    logic            cmd_illegal;
    logic [7:0]      cmd_header;

    router_lfsr8 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .seed   (cmd_seed),
        .q      (lfsr_q)
    );

    assign cmd_illegal = (cmd_addr == ADDR_ILLEGAL) || (cmd_len == 6'd0) ||
                         (32'(cmd_len) > MAX_LEN);
    assign cmd_header  = make_header(cmd_len, cmd_addr);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        bad_d     = bad_q;
        cnt_d     = cnt_q;
        parity_d  = parity_q;
        gap_d     = gap_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ready_d   = 1'b0;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready_d  = 1'b1;
                data_d   = 8'h00;
                valid_d  = 1'b0;
                active_d = 1'b0;
                if (cmd_valid && ready_q) begin
                    if (cmd_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = StHeader;
                        ready_d   = 1'b0;
                        len_d     = cmd_len;
                        bad_d     = cmd_bad_parity;
                        parity_d  = 8'h00;
                        data_d    = cmd_header;
                        valid_d   = 1'b1;
                        active_d  = 1'b1;
                        lfsr_load = 1'b1;
                    end
                end
            end
            StHeader: begin
                if (!busy) begin
                    state_d  = StPayload;
                    cnt_d    = 6'd0;
                    parity_d = parity_q ^ data_q;
                    data_d   = lfsr_q;
                end
            end
            StPayload: begin
                if (!busy) begin
                    parity_d = parity_q ^ data_q;
                    if (cnt_q == len_q - 6'd1) begin
                        state_d = StParity;
                        data_d  = parity_d ^ {8{bad_q}};
                        valid_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 6'd1;
                        lfsr_en = 1'b1;
                        data_d  = lfsr_step(lfsr_q);
                    end
                end
            end
            StParity: begin
                if (!busy) begin
                    state_d  = StGap;
                    gap_d    = '0;
                    done_d   = 1'b1;
                    data_d   = 8'h00;
                    active_d = 1'b0;
                end
            end
            StGap: begin
                // busy is deliberately ignored while counting out the gap.
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: begin
                state_d  = StIdle;
                data_d   = 8'h00;
                valid_d  = 1'b0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            len_q    <= 6'd0;
            bad_q    <= 1'b0;
            cnt_q    <= 6'd0;
            parity_q <= 8'h00;
            gap_q    <= '0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bad_q    <= bad_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            gap_q    <= gap_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign pkt_valid = valid_q;
    assign data_out  = data_q;
    assign tx_active = active_q;
    assign tx_done   = done_q;
    assign cmd_err   = err_q;

endmodule
